paddle_ctl: RTL and testbench
=============================

PADDLE_CTL -- requirements
Module: paddle_ctl

Interface
REQ-001 Parameter SCREENHEIGHT, 480, playfield height in lines.
REQ-002 Parameter PADDLESIZE, 64, paddle height in lines.
REQ-003 Parameter IDLE_FRAMES, 600, frames with no encoder motion before auto takeover (1..1023).
REQ-004 Parameter AI_STEP, 4, max paddle step per frame in auto/handback (1..15).
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 vsync_pulse  input  1  one-cycle frame-start strobe.
REQ-008 enc_pos  input  10  paddle position from quadrature encoder block, already limited.
REQ-009 enc_move  input  1  one-cycle pulse whenever encoder count changes.
REQ-010 ball_y  input  10  current ball vertical centre.
REQ-011 ball_approach  input  1  level, ball travelling toward this paddle.
REQ-012 force_manual  input  1  level, inhibits auto takeover.
REQ-013 paddle_y  output  10  registered paddle centre used by renderer/collision.
REQ-014 auto_mode  output  1  high in AUTO or HANDBACK.
REQ-015 frame_done  output  1  one-cycle pulse, cycle after vsync_pulse, paddle_y updated.

Function
REQ-016 States SHALL be MANUAL, AUTO, HANDBACK; all state, paddle_y and idle-counter updates SHALL occur only on cycles with vsync_pulse=1 (frame tick), except the motion flag.
REQ-017 Motion flag SHALL be set by enc_move on any cycle and cleared on frame tick; at a tick, frame_moved = flag OR enc_move (same-cycle pulse counts for closing frame).
REQ-018 Idle counter (10 bit) SHALL reset to 0 on tick if frame_moved or force_manual, else increment, saturating at IDLE_FRAMES.
REQ-019 MANUAL: on tick paddle_y <= enc_pos; go AUTO when counter reaches IDLE_FRAMES with this tick's increment and force_manual=0.
REQ-020 AUTO: on tick target = ball_y if ball_approach else SCREENHEIGHT/2; paddle_y moves toward target by min(AI_STEP, |target-paddle_y|).
REQ-021 AUTO -> HANDBACK on tick with frame_moved=1 or force_manual=1; that tick performs the HANDBACK step instead of the AI step.
REQ-022 HANDBACK: on tick paddle_y moves toward enc_pos by min(AI_STEP, |diff|); when resulting paddle_y equals enc_pos go MANUAL.
REQ-023 HANDBACK SHALL not return to AUTO; idle counter keeps counting and takeover is evaluated only from MANUAL.
REQ-024 Every computed paddle_y SHALL be clamped to [PADDLESIZE/2, SCREENHEIGHT-PADDLESIZE/2]; difference arithmetic SHALL be 11-bit signed, no wrap.
REQ-025 auto_mode SHALL be registered, reflecting state after the tick, changing in same cycle as paddle_y.
REQ-026 frame_done SHALL assert exactly one cycle after each vsync_pulse, in every state.
REQ-027 Back-to-back vsync_pulse cycles SHALL each be processed as independent ticks.

Reset
REQ-028 On reset: state MANUAL, paddle_y=SCREENHEIGHT/2, idle counter 0, motion flag 0, auto_mode 0, frame_done 0.
REQ-029 Reset asserted mid-AUTO or mid-HANDBACK SHALL abandon motion immediately; first tick after release behaves as MANUAL.

Verification (SCREENHEIGHT=480, PADDLESIZE=64, IDLE_FRAMES=4, AI_STEP=4)
REQ-030 Reset release, enc_pos=100, enc_move each frame, 3 ticks -> paddle_y=240 until first tick, then 100, auto_mode=0, frame_done per tick.
REQ-031 enc_pos=100, no enc_move, 4 ticks -> auto_mode=1 after 4th tick; ball_approach=1, ball_y=300 -> paddle_y 104,108,112 on next ticks.
REQ-032 AUTO at paddle_y=30-target case: ball_y=10, ball_approach=1, paddle_y=34 -> next tick paddle_y=32 (clamped), stays 32.
REQ-033 AUTO paddle_y=120, enc_pos=110, enc_move same cycle as tick -> HANDBACK paddle_y=116, then 112, 110, state MANUAL, auto_mode=0.
REQ-034 force_manual=1 with no motion for 10 ticks -> auto_mode stays 0, idle counter 0; deassert -> auto after 4 ticks.
REQ-035 Reset pulse while in HANDBACK -> paddle_y=240, auto_mode=0 immediately; next tick paddle_y=enc_pos.

Source files
------------

// File: rtl/paddle_if.sv
// Frame-tick, encoder, ball and paddle-output signals shared between the paddle
// controller and its environment.
interface paddle_if;
  logic       vsync_pulse;
  logic [9:0] enc_pos;
  logic       enc_move;
  logic [9:0] ball_y;
  logic       ball_approach;
  logic       force_manual;
  logic [9:0] paddle_y;
  logic       auto_mode;
  logic       frame_done;

  modport slave (
    input  vsync_pulse, enc_pos, enc_move, ball_y, ball_approach, force_manual,
    output paddle_y, auto_mode, frame_done
  );

  modport master (
    output vsync_pulse, enc_pos, enc_move, ball_y, ball_approach, force_manual,
    input  paddle_y, auto_mode, frame_done
  );
endinterface

// File: rtl/paddle_ctl.sv
// Paddle position controller: follows the encoder, hands over to a ball-tracking
// auto player after a run of idle frames, and glides back to the encoder on motion.
module paddle_ctl #(
  parameter int unsigned SCREENHEIGHT = 480,
  parameter int unsigned PADDLESIZE   = 64,
  parameter int unsigned IDLE_FRAMES  = 600,
  parameter int unsigned AI_STEP      = 4
) (
  input logic     clk,
  input logic     reset,
  paddle_if.slave bus
);

  typedef enum logic [1:0] {StManual, StAuto, StHandback} state_e;

  localparam logic signed [10:0] YMin    = 11'(PADDLESIZE / 2);
  localparam logic signed [10:0] YMax    = 11'(SCREENHEIGHT - PADDLESIZE / 2);
  localparam logic signed [10:0] Step    = 11'(AI_STEP);
  localparam logic        [9:0]  YMid    = 10'(SCREENHEIGHT / 2);
  localparam logic        [9:0]  IdleMax = 10'(IDLE_FRAMES);

  state_e     state_q, state_d;
  logic [9:0] paddle_q, paddle_d;
  logic [9:0] idle_q, idle_d;
  logic       moved_q, moved_d;
  logic       auto_q, auto_d;
  logic       done_q;
  logic       frame_moved;
  logic [9:0] target;

  function automatic logic [9:0] clamp(input logic signed [10:0] v);
    if (v < YMin) return 10'(YMin);
    if (v > YMax) return 10'(YMax);
    return 10'(v);
  endfunction

  // Move cur toward tgt by at most AI_STEP, in signed 11-bit so nothing wraps.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] c, t, diff, nxt;
    c    = $signed({1'b0, cur});
    t    = $signed({1'b0, tgt});
    diff = t - c;
    if (diff > Step)       nxt = c + Step;
    else if (diff < -Step) nxt = c - Step;
    else                   nxt = t;
    return clamp(nxt);
  endfunction

  assign frame_moved = moved_q | bus.enc_move;

  always_comb begin
    state_d  = state_q;
    paddle_d = paddle_q;
    idle_d   = idle_q;
    moved_d  = moved_q | bus.enc_move;
    auto_d   = auto_q;
    target   = bus.ball_approach ? bus.ball_y : YMid;

    if (bus.vsync_pulse) begin
      moved_d = 1'b0;
      if (frame_moved || bus.force_manual) idle_d = '0;
      else if (idle_q < IdleMax)           idle_d = idle_q + 10'd1;

      case (state_q)
        StManual: begin
          paddle_d = clamp($signed({1'b0, bus.enc_pos}));
          if (idle_d == IdleMax && !bus.force_manual) state_d = StAuto;
        end
        StAuto: begin
          // Motion or override hands back on this same tick, using the handback step.
          if (frame_moved || bus.force_manual) begin
            paddle_d = step_toward(paddle_q, bus.enc_pos);
            state_d  = (paddle_d == bus.enc_pos) ? StManual : StHandback;
          end else begin
            paddle_d = step_toward(paddle_q, target);
          end
        end
        StHandback: begin
          paddle_d = step_toward(paddle_q, bus.enc_pos);
          if (paddle_d == bus.enc_pos) state_d = StManual;
        end
        default: state_d = StManual;
      endcase

      auto_d = (state_d != StManual);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StManual;
      paddle_q <= YMid;
      idle_q   <= '0;
      moved_q  <= 1'b0;
      auto_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddle_q <= paddle_d;
      idle_q   <= idle_d;
      moved_q  <= moved_d;
      auto_q   <= auto_d;
      done_q   <= bus.vsync_pulse;
    end
  end

  assign bus.paddle_y   = paddle_q;
  assign bus.auto_mode  = auto_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed bench for paddle_ctl: a table of per-frame vectors plus hand-written
// sequences for reset mid-handback, back-to-back ticks and between-tick motion.
module tb_paddle_ctl;

  logic clk = 1'b0;
  logic reset;
  paddle_if bus ();

  paddle_ctl #(
    .SCREENHEIGHT(480),
    .PADDLESIZE  (64),
    .IDLE_FRAMES (4),
    .AI_STEP     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned enc_pos;
    bit          enc_move;
    int unsigned ball_y;
    bit          ball_approach;
    bit          force_manual;
    int unsigned exp_y;
    bit          exp_auto;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int unsigned ep, input bit em, input int unsigned by,
                              input bit ba, input bit fm, input int unsigned ey, input bit ea);
    vec_t v;
    v.enc_pos = ep; v.enc_move = em; v.ball_y = by; v.ball_approach = ba;
    v.force_manual = fm; v.exp_y = ey; v.exp_auto = ea;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.enc_pos       = 10'(v.enc_pos);
    bus.enc_move      = v.enc_move;
    bus.ball_y        = 10'(v.ball_y);
    bus.ball_approach = v.ball_approach;
    bus.force_manual  = v.force_manual;
  endtask

  // One frame tick: vsync for one cycle, check result, then check frame_done drops.
  task automatic do_tick(input vec_t v, input int idx);
    drive(v);
    bus.vsync_pulse = 1'b1;
    @(negedge clk);
    bus.vsync_pulse = 1'b0;
    bus.enc_move    = 1'b0;
    check("paddle_y", idx, int'(bus.paddle_y), int'(v.exp_y));
    check("auto_mode", idx, int'(bus.auto_mode), int'(v.exp_auto));
    check("frame_done_hi", idx, int'(bus.frame_done), 1);
    @(negedge clk);
    check("frame_done_lo", idx, int'(bus.frame_done), 0);
  endtask

  initial begin
    // Manual tracking with motion every frame.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(100, 1, 0, 0, 0, 100, 0));
    // Four idle frames -> auto on the fourth.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(100, 0, 0, 0, 0, 100, 0));
    vecs.push_back(mk(100, 0, 0, 0, 0, 100, 1));
    // Auto chases ball at 300.
    vecs.push_back(mk(100, 0, 300, 1, 0, 104, 1));
    vecs.push_back(mk(100, 0, 300, 1, 0, 108, 1));
    vecs.push_back(mk(100, 0, 300, 1, 0, 112, 1));
    vecs.push_back(mk(100, 0, 300, 1, 0, 116, 1));
    vecs.push_back(mk(100, 0, 300, 1, 0, 120, 1));
    // Same-tick motion: handback 120 -> 116 -> 112 -> 110, then manual.
    vecs.push_back(mk(110, 1, 300, 1, 0, 116, 1));
    vecs.push_back(mk(110, 0, 300, 1, 0, 112, 1));
    vecs.push_back(mk(110, 0, 300, 1, 0, 110, 0));
    // Park at 34, go auto, ball at 10 -> clamped at 32.
    vecs.push_back(mk(34, 1, 10, 1, 0, 34, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(34, 0, 10, 1, 0, 34, 0));
    vecs.push_back(mk(34, 0, 10, 1, 0, 34, 1));
    vecs.push_back(mk(34, 0, 10, 1, 0, 32, 1));
    vecs.push_back(mk(34, 0, 10, 1, 0, 32, 1));
    // force_manual hands back (32 -> 34 reached at once), then holds manual.
    vecs.push_back(mk(34, 0, 10, 1, 1, 34, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(200, 0, 10, 1, 1, 200, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(200, 0, 10, 1, 0, 200, 0));
    vecs.push_back(mk(200, 0, 10, 1, 0, 200, 1));
    // Auto without approach centres toward 240.
    vecs.push_back(mk(200, 0, 10, 0, 0, 204, 1));
    vecs.push_back(mk(200, 0, 10, 0, 0, 208, 1));
    // Enter handback toward 150.
    vecs.push_back(mk(150, 1, 10, 0, 0, 204, 1));

    reset           = 1'b1;
    bus.vsync_pulse = 1'b0;
    drive(mk(100, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("rst_paddle_y", 0, int'(bus.paddle_y), 240);
    check("rst_auto_mode", 0, int'(bus.auto_mode), 0);
    check("rst_frame_done", 0, int'(bus.frame_done), 0);
    reset = 1'b0;
    @(negedge clk);
    check("pre_tick_paddle_y", 0, int'(bus.paddle_y), 240);

    for (int i = 0; i < vecs.size(); i++) do_tick(vecs[i], i);

    // Reset mid-handback: immediate return to centre, manual.
    reset = 1'b1;
    #1;
    check("rst_hb_paddle_y", 0, int'(bus.paddle_y), 240);
    check("rst_hb_auto_mode", 0, int'(bus.auto_mode), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_tick(mk(150, 0, 300, 1, 0, 150, 0), 100);
    do_tick(mk(150, 0, 300, 1, 0, 150, 0), 101);
    do_tick(mk(150, 0, 300, 1, 0, 150, 0), 102);
    do_tick(mk(150, 0, 300, 1, 0, 150, 1), 103);

    // Back-to-back ticks in auto: two independent steps.
    bus.vsync_pulse = 1'b1;
    @(negedge clk);
    check("b2b_paddle_y", 1, int'(bus.paddle_y), 154);
    check("b2b_frame_done", 1, int'(bus.frame_done), 1);
    @(negedge clk);
    bus.vsync_pulse = 1'b0;
    check("b2b_paddle_y", 2, int'(bus.paddle_y), 158);
    check("b2b_frame_done", 2, int'(bus.frame_done), 1);
    @(negedge clk);
    check("b2b_frame_done_lo", 3, int'(bus.frame_done), 0);

    // Motion between ticks is remembered for the next tick.
    bus.enc_move = 1'b1;
    @(negedge clk);
    bus.enc_move = 1'b0;
    @(negedge clk);
    check("flag_hold_auto", 0, int'(bus.auto_mode), 1);
    check("flag_hold_y", 0, int'(bus.paddle_y), 158);
    do_tick(mk(150, 0, 300, 1, 0, 154, 1), 200);
    do_tick(mk(150, 0, 300, 1, 0, 150, 0), 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
